// File: rtl/ras_ctrl.sv
// Return-address stack controller: TOS/NOS held in registers, deeper entries spill to a RAM.
// Define RAS_STATS_EN to add saturating ovf_cnt/udf_cnt event counters.
module ras_ctrl #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 36,
   localparam int CNTW = $clog2(DEPTH + 3),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_addr,
   input  logic             pop,
   input  logic             flush,
   output logic             tos_valid,
   output logic [WIDTH-1:0] tos_addr,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_addr,
   output logic [CNTW-1:0]  count,
   output logic             ovf,
   output logic             udf,
   output logic             ram_we,
   output logic [AW-1:0]    ram_waddr,
   output logic [WIDTH-1:0] ram_wdata,
   output logic             ram_re,
   output logic [AW-1:0]    ram_raddr,
   input  logic [WIDTH-1:0] ram_rdata
`ifdef RAS_STATS_EN
   ,
   output logic [15:0]      ovf_cnt,
   output logic [15:0]      udf_cnt
`endif
);

   localparam logic [CNTW-1:0] FULL  = CNTW'(DEPTH + 2);
   localparam logic [CNTW-1:0] TWO   = CNTW'(2);
   localparam logic [CNTW-1:0] THREE = CNTW'(3);

   logic [WIDTH-1:0] tos_q, nos_q, tos_d, nos_d;
   logic [WIDTH-1:0] nos_eff, pa_q, pa_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]    bsp_q, bsp_d;
   logic             fill_q, fill_d;
   logic             pv_q, pv_d;
   logic             we_c, re_c, ovf_c, udf_c;
   logic             do_flush, do_xchg, do_push, do_pop;

   assign nos_eff = fill_q ? ram_rdata : nos_q;

   // A push+pop on an empty stack degenerates into a plain push.
   assign do_flush = flush;
   assign do_xchg  = !flush && push && pop && (cnt_q != '0);
   assign do_push  = !flush && push && (!pop || (cnt_q == '0));
   assign do_pop   = !flush && pop && !push;

   always_comb begin
      tos_d  = tos_q;
      nos_d  = nos_q;
      cnt_d  = cnt_q;
      bsp_d  = bsp_q;
      fill_d = 1'b0;
      pv_d   = 1'b0;
      pa_d   = pa_q;
      we_c   = 1'b0;
      re_c   = 1'b0;
      ovf_c  = 1'b0;
      udf_c  = 1'b0;
      if (fill_q)
         nos_d = ram_rdata;
      unique case (1'b1)
         do_flush: begin
            cnt_d = '0;
            bsp_d = '0;
         end
         do_xchg: begin
            pv_d  = 1'b1;
            pa_d  = tos_q;
            tos_d = push_addr;
            nos_d = nos_eff;
         end
         do_push: begin
            tos_d = push_addr;
            nos_d = tos_q;
            // A pending fill means the old NOS still sits in RAM at bsp.
            if (fill_q) begin
               bsp_d = bsp_q + 1'b1;
            end else if (cnt_q >= TWO) begin
               we_c  = 1'b1;
               bsp_d = bsp_q + 1'b1;
            end
            if (cnt_q != FULL)
               cnt_d = cnt_q + 1'b1;
            else
               ovf_c = 1'b1;
         end
         do_pop: begin
            if (cnt_q == '0) begin
               udf_c = 1'b1;
            end else begin
               pv_d  = 1'b1;
               pa_d  = tos_q;
               tos_d = nos_eff;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q >= THREE) begin
                  re_c   = 1'b1;
                  bsp_d  = bsp_q - 1'b1;
                  fill_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tos_q  <= '0;
         nos_q  <= '0;
         cnt_q  <= '0;
         bsp_q  <= '0;
         fill_q <= 1'b0;
         pv_q   <= 1'b0;
         pa_q   <= '0;
      end else begin
         tos_q  <= tos_d;
         nos_q  <= nos_d;
         cnt_q  <= cnt_d;
         bsp_q  <= bsp_d;
         fill_q <= fill_d;
         pv_q   <= pv_d;
         pa_q   <= pa_d;
      end
   end

`ifdef RAS_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_cnt <= '0;
         udf_cnt <= '0;
      end else begin
         if (ovf_c && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
         if (udf_c && (udf_cnt != 16'hFFFF))
            udf_cnt <= udf_cnt + 16'd1;
      end
   end
`endif

   assign tos_valid = (cnt_q != '0);
   assign tos_addr  = tos_q;
   assign pop_valid = pv_q;
   assign pop_addr  = pa_q;
   assign count     = cnt_q;
   assign ovf       = rst_n & ovf_c;
   assign udf       = rst_n & udf_c;
   assign ram_we    = rst_n & we_c;
   assign ram_waddr = bsp_q;
   assign ram_wdata = nos_q;
   assign ram_re    = rst_n & re_c;
   assign ram_raddr = bsp_q - 1'b1;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios plus random traffic against a queue model.
// Includes a behavioural 1-cycle-read RAM; checks stats ports when RAS_STATS_EN is set.
module tb_ras_ctrl;
   localparam int DEPTH = 4;
   localparam int WIDTH = 36;
   localparam int CNTW = $clog2(DEPTH + 3);
   localparam int AW = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             push = 1'b0;
   logic [WIDTH-1:0] push_addr = '0;
   logic             pop = 1'b0;
   logic             flush = 1'b0;
   logic             tos_valid, pop_valid, ovf, udf, ram_we, ram_re;
   logic [WIDTH-1:0] tos_addr, pop_addr, ram_wdata;
   logic [WIDTH-1:0] ram_rdata = '0;
   logic [CNTW-1:0]  count;
   logic [AW-1:0]    ram_waddr, ram_raddr;
`ifdef RAS_STATS_EN
   logic [15:0]      ovf_cnt, udf_cnt;
   int               n_ovf = 0, n_udf = 0;
`endif

   ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .push(push), .push_addr(push_addr),
      .pop(pop), .flush(flush),
      .tos_valid(tos_valid), .tos_addr(tos_addr),
      .pop_valid(pop_valid), .pop_addr(pop_addr),
      .count(count), .ovf(ovf), .udf(udf),
      .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_re(ram_re),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
`ifdef RAS_STATS_EN
      , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] stk [$];
   logic             exp_pv = 1'b0;
   logic [WIDTH-1:0] exp_pa = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs at negedge and check the same-cycle pulses.
   task automatic drive(input logic p, input logic [WIDTH-1:0] a,
                        input logic po, input logic f);
      logic e_ovf, e_udf;
      @(negedge clk);
      push = p; push_addr = a; pop = po; flush = f;
      #1;
      e_ovf = !f && p && !po && (stk.size() == DEPTH + 2);
      e_udf = !f && po && !p && (stk.size() == 0);
      chk("ovf", ovf, e_ovf);
      chk("udf", udf, e_udf);
`ifdef RAS_STATS_EN
      if (e_ovf) n_ovf++;
      if (e_udf) n_udf++;
`endif
   endtask

   // Clock edge, advance the stack model, check registered state.
   task automatic tick();
      @(posedge clk);
      #1;
      if (flush) begin
         stk.delete();
         exp_pv = 1'b0;
      end else if (push && pop && stk.size() != 0) begin
         exp_pv = 1'b1;
         exp_pa = stk[stk.size()-1];
         stk[stk.size()-1] = push_addr;
      end else if (push) begin
         if (stk.size() == DEPTH + 2) void'(stk.pop_front());
         stk.push_back(push_addr);
         exp_pv = 1'b0;
      end else if (pop && stk.size() != 0) begin
         exp_pv = 1'b1;
         exp_pa = stk.pop_back();
      end else begin
         exp_pv = 1'b0;
      end
      chk("count", count, stk.size());
      chk("tos_valid", tos_valid, stk.size() != 0);
      if (stk.size() != 0) chk("tos_addr", tos_addr, stk[stk.size()-1]);
      chk("pop_valid", pop_valid, exp_pv);
      if (exp_pv) chk("pop_addr", pop_addr, exp_pa);
   endtask

   task automatic op(input logic p, input logic [WIDTH-1:0] a,
                     input logic po, input logic f);
      drive(p, a, po, f);
      tick();
   endtask

   initial begin
      int pp;
      logic [WIDTH-1:0] r;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tos_valid", tos_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_pop_valid", pop_valid, 1'b0);
      chk("rst_pop_addr", pop_addr, 0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_udf", udf, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_re", ram_re, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four pushes, spills of A1/A2, then four pops draining through RAM.
      op(1, 36'hA1, 0, 0);
      op(1, 36'hA2, 0, 0);
      drive(1, 36'hA3, 0, 0);
      chk("spill0_we", ram_we, 1'b1);
      chk("spill0_addr", ram_waddr, 0);
      chk("spill0_data", ram_wdata, 36'hA1);
      tick();
      drive(1, 36'hA4, 0, 0);
      chk("spill1_we", ram_we, 1'b1);
      chk("spill1_addr", ram_waddr, 1);
      chk("spill1_data", ram_wdata, 36'hA2);
      tick();
      drive(0, '0, 1, 0);
      chk("fill0_re", ram_re, 1'b1);
      chk("fill0_addr", ram_raddr, 1);
      tick();
      drive(0, '0, 1, 0);
      chk("fill1_re", ram_re, 1'b1);
      chk("fill1_addr", ram_raddr, 0);
      tick();
      drive(0, '0, 1, 0);
      chk("fill2_re", ram_re, 1'b0);
      tick();
      op(0, '0, 1, 0);
      op(0, '0, 1, 0);
      op(0, '0, 0, 0);

      // Overflow: V0 is lost.
      for (int i = 0; i < 7; i++) op(1, 36'h100 + WIDTH'(i), 0, 0);
      for (int i = 0; i < 7; i++) op(0, '0, 1, 0);

      // Push right after a pop with a fill pending: no spill write.
      op(1, 36'h0F00, 0, 0);
      op(1, 36'h0F01, 0, 0);
      op(1, 36'h0F02, 0, 0);
      op(1, 36'h0F03, 0, 0);
      op(0, '0, 1, 0);
      drive(1, 36'h0F0A, 0, 0);
      chk("fillpend_no_we", ram_we, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) op(0, '0, 1, 0);

      // Simultaneous push/pop at count 3, then flush.
      op(1, 36'hB0, 0, 0);
      op(1, 36'hB1, 0, 0);
      op(1, 36'hB2, 0, 0);
      op(1, 36'hB3, 1, 0);
      op(0, '0, 0, 1);
      op(1, 36'hC0, 1, 0);
      op(0, '0, 1, 0);

      // Reset while a fill is in flight.
      for (int i = 0; i < 4; i++) op(1, 36'hD0 + WIDTH'(i), 0, 0);
      op(0, '0, 1, 0);
      @(negedge clk);
      rst_n = 1'b0; push = 0; pop = 0; flush = 0;
      @(posedge clk);
      #1;
      stk.delete();
      exp_pv = 1'b0;
      chk("midrst_count", count, 0);
      chk("midrst_pop_valid", pop_valid, 1'b0);
      chk("midrst_pop_addr", pop_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      op(1, 36'hE0, 0, 0);
      op(1, 36'hE1, 0, 0);
      op(0, '0, 1, 0);
      op(0, '0, 1, 0);

      // Random traffic: push-heavy half, then pop-heavy half.
      for (int i = 0; i < 600; i++) begin
         pp = (i < 300) ? 65 : 35;
         r = WIDTH'({$urandom(), $urandom()});
         op($urandom_range(0, 99) < pp, r,
            $urandom_range(0, 99) < (100 - pp),
            $urandom_range(0, 99) < 3);
      end
      op(0, '0, 0, 0);

`ifdef RAS_STATS_EN
      chk("ovf_cnt", ovf_cnt, n_ovf);
      chk("udf_cnt", udf_cnt, n_udf);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller sitting between the fetch/branch-predictor and a dual-port RAS block RAM (1-cycle registered read).
- Keeps the top two entries (TOS, NOS) in registers and spills/fills deeper entries to the RAM. Port A is write-only (spill); port B is read-only (fill).
- Sustains one push or one pop per cycle, including back-to-back pops, with a zero-latency top-of-stack output.
- Circular overflow: the oldest entry is overwritten.

Parameters:
- DEPTH, 1024, RAM entries; power of 2, at least 4.
- WIDTH, 36, return address width.
- CNTW, $clog2(DEPTH+3), width of the occupancy count (local).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- push  in  1  call: push push_addr
- push_addr  in  WIDTH  return address to push
- pop  in  1  return: pop the TOS
- flush  in  1  empty the stack
- tos_valid  out  1  stack non-empty
- tos_addr  out  WIDTH  current TOS (combinational from register)
- pop_valid  out  1  registered; previous-cycle pop hit a valid entry
- pop_addr  out  WIDTH  registered popped address
- count  out  CNTW  total valid entries, 0..DEPTH+2
- ovf  out  1  1-cycle pulse: push discarded the oldest entry
- udf  out  1  1-cycle pulse: pop on an empty stack
- ram_we  out  1  to RAM wea
- ram_waddr  out  $clog2(DEPTH)  to RAM waddra
- ram_wdata  out  WIDTH  to RAM wia
- ram_re  out  1  to RAM reb
- ram_raddr  out  $clog2(DEPTH)  to RAM raddrb
- ram_rdata  in  WIDTH  from RAM dob
- RAM rea/web are tied low at the parent.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: tos_valid=0, count=0, bsp=0, fill_pend=0, pop_valid=0, pop_addr=0, ovf=0, udf=0, ram_we=0, ram_re=0. TOS/NOS registers reset to 0. RAM contents are not cleared.
- State:
  - tos_q, nos_q.
  - bsp: next free RAM index, mod DEPTH.
  - fill_pend: a RAM read was issued last cycle; NOS is to be taken from ram_rdata.
  - nos_eff = fill_pend ? ram_rdata : nos_q.
  - ram entries = max(count-2, 0).
- Priority: flush > (push&pop) > push > pop.
- flush: count<=0, fill_pend<=0, bsp<=0. No RAM access. tos_valid=0 next cycle.
- push only:
  - tos<=push_addr; nos<=tos_q.
  - If count>=2 and !fill_pend: ram_we=1, waddr=bsp, wdata=nos_q, bsp<=bsp+1.
  - If fill_pend: no write (the entry is still in RAM at bsp); bsp<=bsp+1; fill_pend<=0.
  - If count<DEPTH+2: count++. Otherwise count holds and ovf=1 (the write wraps over the oldest entry).
- pop only:
  - If count==0: udf=1, pop_valid<=0, no state change.
  - Otherwise: pop_valid<=1, pop_addr<=tos_q, tos<=nos_eff, count--.
  - If count>=3: ram_re=1, raddr=bsp-1, bsp<=bsp-1, fill_pend<=1. Otherwise fill_pend<=0.
- push & pop (same cycle): pop_valid<=1 (if count>0), pop_addr<=tos_q, tos<=push_addr. NOS, bsp and count are unchanged. fill_pend resolves: nos_q<=nos_eff, fill_pend<=0. If count==0, this acts as a plain push and udf is not raised.
- Idle cycle with fill_pend=1: nos_q<=ram_rdata, fill_pend<=0.
- tos_valid = (count!=0); tos_addr = tos_q, valid the same cycle after any update.
- Wrap: bsp and addresses wrap mod DEPTH. Read/write on the same index in one cycle never occurs, because push and pop are mutually resolved.
- Reset mid-fill: the in-flight ram_rdata is ignored.

Optional Feature:
- Macro: RAS_STATS_EN.
- Defined:
  - Adds outputs ovf_cnt[15:0] and udf_cnt[15:0].
  - Each is a saturating count of ovf/udf pulses, reset to 0 by rst_n. Flush does not clear them.
- Undefined: the ports and logic are absent; other behaviour is identical.

Test Plan:
- Reset, then push A1,A2,A3,A4 on consecutive cycles → count=4; ram writes A1@0, A2@1; tos_addr=A4.
- Then 4 back-to-back pops → pop_addr A4,A3,A2,A1 on consecutive cycles, with pop_valid=1 each; ram_re at raddr 1, 0; count=0.
- Fifth pop → udf=1, pop_valid=0, count stays 0.
- DEPTH=4: push 7 values V0..V6 → ovf=1 on the 7th push, count=6. Pop 6 → V6..V1 returned, V0 lost.
- Push X, Y, Z, W, pop, then immediate push Q (fill pending) → no RAM write that cycle. The next pops return Q, Z, Y, X.
- Push B,C while count=3, same-cycle push D & pop → pop_addr=C, tos=D, count unchanged. Then flush → tos_valid=0 the next cycle.
